ps2_key_rx: RTL and testbench
=============================

PS2_KEY_RX -- requirements
Module: ps2_key_rx

Interface
REQ-001 Parameter FILTER, default 8: consecutive equal synchronized samples required to change the filtered PS/2 clock level.
REQ-002 Parameter TIMEOUT, default 12000: clk cycles without a filtered falling edge after which a partial frame is abandoned.
REQ-003 Port clk input 1: single system clock; all state changes on its rising edge.
REQ-004 Port reset_n input 1: asynchronous, active-low reset.
REQ-005 Port ps2_clk input 1: raw PS/2 clock line, asynchronous to clk.
REQ-006 Port ps2_data input 1: raw PS/2 data line, asynchronous to clk.
REQ-007 Port ps2_key output 11: [10] toggle (inverts once per key event), [9] 1=press/0=release, [8] extended (E0 prefix), [7:0] scancode; consumed by the keyboard matrix stage.
REQ-008 Port ps2_err output 1: one-cycle pulse on a discarded frame (bad start, parity, stop, or timeout).

Function
REQ-009 The block SHALL pass ps2_clk and ps2_data each through a 2-flop synchronizer before any use.
REQ-010 The filtered clock SHALL change level only after FILTER consecutive synchronized samples differ from it; the counter clears on any sample equal to the current filtered level.
REQ-011 A falling edge SHALL be detected for exactly one cycle when filtered clock goes 1->0; the synchronized data bit is sampled in that same cycle.
REQ-012 Frame FSM states: IDLE, DATA, PARITY, STOP; all transitions occur only on a detected falling edge or a timeout.
REQ-013 IDLE: sampled 0 -> DATA, bit counter cleared; sampled 1 -> stay IDLE, pulse ps2_err.
REQ-014 DATA: shift bit in LSB-first; after the 8th bit -> PARITY.
REQ-015 PARITY: record bit -> STOP; odd parity is valid (ones count over 8 data + parity bit is odd).
REQ-016 STOP: sampled 1 and parity valid -> byte_valid one cycle, IDLE; otherwise pulse ps2_err, IDLE, no byte.
REQ-017 Timeout counter SHALL clear on every falling edge and in IDLE; on reaching TIMEOUT in a non-IDLE state, FSM returns to IDLE, pulses ps2_err, and clears the prefix flags.
REQ-018 Byte decoder, on byte_valid: 0xE0 sets ext flag; 0xF0 sets rel flag; any other byte SHALL load ps2_key <= {~ps2_key[10], ~rel, ext, byte} and clear both flags.
REQ-019 ps2_key SHALL update on the 2nd clk edge after the edge that detects the stop-bit falling edge; it holds value between events.
REQ-020 Any discarded frame (REQ-013/016/017) SHALL clear ext and rel so a corrupted prefix never attaches to a later code.
REQ-021 Prefix order E0 then F0 and F0 alone SHALL both be accepted; repeated E0 or F0 bytes keep the flag set without emitting.
REQ-022 Typematic repeats (same make code again) SHALL each produce a new event with toggled bit [10].
REQ-023 ps2_err and ps2_key updates are independent; both may occur in the same cycle only after a timeout following a valid byte, and both then take effect.

Reset
REQ-024 While reset_n is low: FSM IDLE, bit/timeout/filter counters 0, synchronizers and filtered clock 1, ext=rel=0, ps2_key=11'h000, ps2_err=0.
REQ-025 Reset asserted mid-frame SHALL abandon the frame with no ps2_key update and no ps2_err pulse; after release the next start bit begins a fresh frame.

Verification
REQ-026 Frame 0x1C, parity 0, stop 1 from reset -> ps2_key = 11'h61C (toggle 1, press, not ext), ps2_err never high.
REQ-027 Frames F0, 1C after REQ-026 -> exactly one update, ps2_key = 11'h01C; no update after the F0 frame alone.
REQ-028 Frames E0, 75 then E0, F0, 75 -> ps2_key 11'h775, then 11'h175.
REQ-029 Frame 0x5A with parity 0 (wrong) -> one ps2_err pulse, ps2_key unchanged; then a valid 0x5A frame -> press of 0x5A with toggled bit [10].
REQ-030 Stop after 4 data bits, idle TIMEOUT+2 cycles -> one ps2_err pulse, FSM IDLE; following valid 0x15 frame -> ps2_key[7:0]=0x15, [9]=1.
REQ-031 Single-cycle 0 glitches on ps2_clk (shorter than FILTER) during idle -> no edge detected, no ps2_err, no state change.

Source files
------------

// File: rtl/ps2_key_rx.sv
// PS/2 keyboard receiver: synchronizes and de-glitches the PS/2 clock,
// frames 11-bit serial words (start, 8 data LSB-first, odd parity, stop),
// and decodes E0/F0 prefixes into a toggle-flagged key event word.
module ps2_key_rx #(
    parameter int FILTER  = 8,
    parameter int TIMEOUT = 12000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [10:0] ps2_key,
    output logic        ps2_err
);

    localparam int FW = (FILTER > 1) ? $clog2(FILTER) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // Synchronizers and clock filter
    logic          r_clk_s1;
    logic          r_clk_s2;
    logic          r_dat_s1;
    logic          r_dat_s2;
    logic          r_clk_filt;
    logic          r_filt_prev;
    logic [FW-1:0] r_filt_cnt;
    logic          w_fall;

    // Frame FSM
    state_t        r_state;
    logic [2:0]    r_bit_cnt;
    logic [7:0]    r_shift;
    logic          r_par_ok;
    logic [TW-1:0] r_to_cnt;
    logic [7:0]    r_byte;
    logic          r_byte_valid;
    logic          r_err;

    // Byte decoder
    logic          r_ext;
    logic          r_rel;
    logic [10:0]   r_key;

    // Two-flop synchronizers on both raw PS/2 lines; idle level of the bus is high.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: the synchronizers reset to 1 (bus idle level) so releasing reset never fakes a falling edge.
            r_clk_s1 <= 1'b1;
            r_clk_s2 <= 1'b1;
            r_dat_s1 <= 1'b1;
            r_dat_s2 <= 1'b1;
        end else begin
            r_clk_s1 <= ps2_clk;
            r_clk_s2 <= r_clk_s1;
            r_dat_s1 <= ps2_data;
            r_dat_s2 <= r_dat_s1;
        end
    end

    // Filtered clock flips only after FILTER consecutive samples disagree with it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_clk_filt  <= 1'b1;
            r_filt_prev <= 1'b1;
            r_filt_cnt  <= '0;
        end else begin
            r_filt_prev <= r_clk_filt;
            if (r_clk_s2 == r_clk_filt) begin
                r_filt_cnt <= '0;
            end else if (r_filt_cnt == FW'(FILTER - 1)) begin
                r_clk_filt <= r_clk_s2;
                r_filt_cnt <= '0;
            end else begin
                r_filt_cnt <= r_filt_cnt + 1'b1;
            end
        end
    end

    // One-cycle strobe on a filtered 1->0 transition; data is sampled with it.
    assign w_fall = r_filt_prev & ~r_clk_filt;

    // Frame FSM with timeout watchdog; emits byte_valid or err as one-cycle pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_par_ok     <= 1'b0;
            r_to_cnt     <= '0;
            r_byte       <= '0;
            r_byte_valid <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_byte_valid <= 1'b0;
            r_err        <= 1'b0;

            if (r_state == S_IDLE || w_fall) begin
                r_to_cnt <= '0;
            end else if (r_to_cnt != TW'(TIMEOUT)) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end

            if (r_state != S_IDLE && !w_fall && r_to_cnt == TW'(TIMEOUT)) begin
                r_state <= S_IDLE;
                r_err   <= 1'b1;
            end else if (w_fall) begin
                case (r_state)
                    S_IDLE: begin
                        if (!r_dat_s2) begin
                            r_state   <= S_DATA;
                            r_bit_cnt <= '0;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                    S_DATA: begin
                        r_shift   <= {r_dat_s2, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        if (r_bit_cnt == 3'd7) begin
                            r_state <= S_PARITY;
                        end
                    end
                    S_PARITY: begin
                        r_par_ok <= ^{r_shift, r_dat_s2};
                        r_state  <= S_STOP;
                    end
                    S_STOP: begin
                        r_state <= S_IDLE;
                        if (r_dat_s2 && r_par_ok) begin
                            r_byte       <= r_shift;
                            r_byte_valid <= 1'b1;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    // Prefix tracking and key event generation; any discarded frame drops pending prefixes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ext <= 1'b0;
            r_rel <= 1'b0;
            r_key <= '0;
        end else begin
            if (r_byte_valid) begin
                if (r_byte == 8'hE0) begin
                    r_ext <= 1'b1;
                end else if (r_byte == 8'hF0) begin
                    r_rel <= 1'b1;
                end else begin
                    r_key <= {~r_key[10], ~r_rel, r_ext, r_byte};
                    r_ext <= 1'b0;
                    r_rel <= 1'b0;
                end
            end
            if (r_err) begin
                r_ext <= 1'b0;
                r_rel <= 1'b0;
            end
        end
    end

    assign ps2_key = r_key;
    assign ps2_err = r_err;

endmodule

// File: tb/tb_ps2_key_rx.sv
// Scoreboard bench for ps2_key_rx: the stimulus thread pushes hand-computed
// key words and expected error pulses; a monitor pops them whenever ps2_key
// changes or ps2_err pulses.
module tb_ps2_key_rx;

    localparam int FILTER  = 8;
    localparam int TIMEOUT = 12000;
    localparam int HALF    = 20;

    logic        clk      = 1'b0;
    logic        reset_n  = 1'b0;
    logic        ps2_clk  = 1'b1;
    logic        ps2_data = 1'b1;
    logic [10:0] ps2_key;
    logic        ps2_err;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [10:0] exp_keys[$];
    int          exp_errs = 0;

    always #5 clk = ~clk;

    ps2_key_rx #(
        .FILTER (FILTER),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .ps2_clk (ps2_clk),
        .ps2_data(ps2_data),
        .ps2_key (ps2_key),
        .ps2_err (ps2_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        ps2_data = b;
        wait_clks(HALF);
        ps2_clk = 1'b0;
        wait_clks(HALF);
        ps2_clk = 1'b1;
    endtask

    function automatic logic odd_par(input logic [7:0] b);
        return ~^b;
    endfunction

    task automatic send_frame(input logic [7:0] b, input logic par, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(par);
        send_bit(stop);
        ps2_data = 1'b1;
        wait_clks(3 * HALF);
    endtask

    task automatic good_frame(input logic [7:0] b);
        send_frame(b, odd_par(b), 1'b1);
    endtask

    // Monitor: compare every key change and every error pulse against the scoreboard.
    initial begin
        logic [10:0] prev;
        prev = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev = ps2_key;
            end else begin
                if (ps2_key !== prev) begin
                    if (exp_keys.size() == 0) check("key_update_unexpected", 32'(ps2_key), 32'(prev));
                    else check("key_update", 32'(ps2_key), 32'(exp_keys.pop_front()));
                    prev = ps2_key;
                end
                if (ps2_err !== 1'b0) begin
                    check("err_pulse_expected", 32'(exp_errs > 0), 32'd1);
                    if (exp_errs > 0) exp_errs--;
                end
            end
        end
    end

    // Watchdog so a stuck run still terminates.
    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    // Stimulus with hand-computed expectations.
    initial begin
        // Reset values
        wait_clks(5);
        check("reset_key", 32'(ps2_key), 32'h000);
        check("reset_err", 32'(ps2_err), 32'd0);
        reset_n = 1'b1;
        wait_clks(10);

        // Plain make code
        exp_keys.push_back(11'h61C);
        good_frame(8'h1C);

        // Break code: no update on F0 alone
        good_frame(8'hF0);
        check("key_hold_after_f0", 32'(ps2_key), 32'h61C);
        exp_keys.push_back(11'h01C);
        good_frame(8'h1C);

        // Extended make, then extended break
        good_frame(8'hE0);
        exp_keys.push_back(11'h775);
        good_frame(8'h75);
        good_frame(8'hE0);
        good_frame(8'hF0);
        exp_keys.push_back(11'h175);
        good_frame(8'h75);

        // Bad parity, then valid frame and typematic repeats
        exp_errs++;
        send_frame(8'h5A, 1'b0, 1'b1);
        check("key_hold_after_bad_parity", 32'(ps2_key), 32'h175);
        exp_keys.push_back(11'h65A);
        good_frame(8'h5A);
        exp_keys.push_back(11'h25A);
        good_frame(8'h5A);
        exp_keys.push_back(11'h65A);
        good_frame(8'h5A);

        // E0 prefix discarded by a bad start bit
        good_frame(8'hE0);
        exp_errs++;
        send_bit(1'b1);
        ps2_data = 1'b1;
        wait_clks(3 * HALF);
        exp_keys.push_back(11'h21C);
        good_frame(8'h1C);

        // F0 prefix discarded by a bad stop bit
        good_frame(8'hF0);
        exp_errs++;
        send_frame(8'h33, odd_par(8'h33), 1'b0);
        exp_keys.push_back(11'h61C);
        good_frame(8'h1C);

        // Partial frame abandoned by timeout
        exp_errs++;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        ps2_data = 1'b1;
        wait_clks(TIMEOUT + 2 + 50);
        check("errs_after_timeout", 32'(exp_errs), 32'd0);
        exp_keys.push_back(11'h215);
        good_frame(8'h15);

        // Single-cycle glitches on ps2_clk while idle
        for (int g = 0; g < 5; g++) begin
            ps2_clk = 1'b0;
            wait_clks(1);
            ps2_clk = 1'b1;
            wait_clks(30);
        end
        check("key_hold_after_glitch", 32'(ps2_key), 32'h215);

        // Repeated prefixes keep the flag set
        good_frame(8'hE0);
        good_frame(8'hE0);
        exp_keys.push_back(11'h775);
        good_frame(8'h75);
        good_frame(8'hF0);
        good_frame(8'hF0);
        exp_keys.push_back(11'h075);
        good_frame(8'h75);

        // Reset in the middle of a frame
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        reset_n = 1'b0;
        wait_clks(5);
        check("midframe_reset_key", 32'(ps2_key), 32'h000);
        check("midframe_reset_err", 32'(ps2_err), 32'd0);
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        wait_clks(2);
        reset_n = 1'b1;
        wait_clks(10);
        exp_keys.push_back(11'h61C);
        good_frame(8'h1C);

        wait_clks(50);
        check("pending_keys", 32'(exp_keys.size()), 32'd0);
        check("pending_errs", 32'(exp_errs), 32'd0);
        check("final_key", 32'(ps2_key), 32'h61C);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
